// File: rtl/level_generator.sv
// level_generator: builds a Simon-style one-hot note sequence for game_core.
// One note is appended per won round; the game is complete at MAX_NOTES notes.
// Notes are drawn from a free-running 16-bit LFSR, so the sequence depends on player timing.
// Optional feature macro: NO_REPEAT_EN (adjacent notes forced to differ).
module level_generator #(
    parameter int unsigned MAX_NOTES = 4,         // 1..15
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   new_game,
    input  logic                   level_won,
    input  logic                   level_lost,
    output logic [4*MAX_NOTES-1:0] level_data,
    output logic [3:0]             level_length,
    output logic                   level_valid,
    output logic                   game_complete
);

    localparam int unsigned W        = 4 * MAX_NOTES;
    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  LEN_MAX  = 4'(MAX_NOTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state_q;
    logic [15:0]  lfsr_q;
    logic [15:0]  lfsr_d;
    logic [W-1:0] data_q;
    logic [3:0]   len_q;
    logic         valid_q;
    logic         complete_q;
    logic [3:0]   cand_note;
    logic [3:0]   note_d;
`ifdef NO_REPEAT_EN
    logic [3:0]   prev_note;
`endif

    // Fibonacci LFSR next value, x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // LFSR advances on every clock regardless of FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Note to be written in GEN: one-hot candidate, optionally rotated to avoid a repeat.
    always_comb begin
        cand_note = 4'b0001 << lfsr_q[1:0];
`ifdef NO_REPEAT_EN
        prev_note = '0;
        for (int unsigned i = 1; i < MAX_NOTES; i++) begin
            if (len_q == 4'(i)) begin
                prev_note = data_q[W-1-4*(i-1) -: 4];
            end
        end
        if ((len_q != '0) && (cand_note == prev_note)) begin
            note_d = {cand_note[2:0], cand_note[3]};
        end else begin
            note_d = cand_note;
        end
`else
        note_d = cand_note;
`endif
    end

    // Level FSM with registered outputs; new_game > level_lost > level_won.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            data_q     <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            complete_q <= 1'b0;
        end else if (new_game) begin
            state_q    <= GEN;
            data_q     <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                GEN: begin
                    // Slot index is the current length; earlier slots are left untouched.
                    for (int unsigned i = 0; i < MAX_NOTES; i++) begin
                        if (len_q == 4'(i)) begin
                            data_q[W-1-4*i -: 4] <= note_d;
                        end
                    end
                    len_q   <= len_q + 4'd1;
                    valid_q <= 1'b1;
                    state_q <= READY;
                end
                READY: begin
                    if (level_lost) begin
                        state_q <= IDLE;
                        data_q  <= '0;
                        len_q   <= '0;
                        valid_q <= 1'b0;
                    end else if (level_won) begin
                        valid_q <= 1'b0;
                        if (len_q == LEN_MAX) begin
                            state_q    <= DONE;
                            complete_q <= 1'b1;
                        end else begin
                            state_q <= GEN;
                        end
                    end
                end
                IDLE, DONE: begin
                    // Only new_game leaves these states.
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign level_data    = data_q;
    assign level_length  = len_q;
    assign level_valid   = valid_q;
    assign game_complete = complete_q;

endmodule

// File: tb/tb_level_generator.sv
// Self-checking bench for level_generator (default MAX_NOTES=4, SEED=16'hACE1).
// Honours NO_REPEAT_EN in the same way as the design.
module tb_level_generator;

    localparam int unsigned MAX_NOTES = 4;
    localparam int unsigned W         = 4 * MAX_NOTES;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         new_game = 1'b0;
    logic         level_won = 1'b0;
    logic         level_lost = 1'b0;
    logic [W-1:0] level_data;
    logic [3:0]   level_length;
    logic         level_valid;
    logic         game_complete;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    level_generator #(
        .MAX_NOTES(MAX_NOTES),
        .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .new_game(new_game),
        .level_won(level_won),
        .level_lost(level_lost),
        .level_data(level_data),
        .level_length(level_length),
        .level_valid(level_valid),
        .game_complete(game_complete)
    );

    // Reference LFSR; lfsr_prev holds the value that was current before the last edge.
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end
    end

    typedef struct packed {
        logic       ng;
        logic       won;
        logic       lost;
        logic       valid;
        logic [3:0] len;
        logic       comp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic ng, input logic won, input logic lost);
        new_game   = ng;
        level_won  = won;
        level_lost = lost;
        @(posedge clk);
        #1;
        new_game   = 1'b0;
        level_won  = 1'b0;
        level_lost = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!level_valid && k < 8) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        if (!level_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_valid: level_valid still 0 after %0d cycles, expected 1", k);
        end
    endtask

    function automatic logic [3:0] exp_note(input logic [15:0] l, input logic [W-1:0] d,
                                            input logic [3:0] slot);
        logic [3:0] c;
        c = 4'b0001 << l[1:0];
`ifdef NO_REPEAT_EN
        if (slot != 4'd0) begin
            if (d[W-1-4*(int'(slot)-1) -: 4] == c) c = {c[2:0], c[3]};
        end
`else
        if (slot == 4'hF && d == '0) c = c; // slot/data unused without the no-repeat rule
`endif
        return c;
    endfunction

    initial begin
        logic [W-1:0] exp_data;
        logic [3:0]   prev_len;
        logic [3:0]   nib;
        int           repeats;
        int           eq_pairs;
        logic         all_onehot;

        // ng won lost | valid len comp
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}); // idle
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}); // won ignored in IDLE
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}); // new_game -> GEN
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0}); // first note
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0}); // won -> GEN
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1}); // won at MAX -> DONE
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1}); // won ignored in DONE
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1}); // lost ignored in DONE
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}); // restart from DONE
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0}); // won+lost -> lost
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}); // won ignored in IDLE
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}); // restart from READY
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}); // restart from GEN
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}); // new_game beats lost
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}); // lost -> IDLE
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(level_data), 32'h0);
        check("rst_len", 32'(level_length), 32'h0);
        check("rst_valid", 32'(level_valid), 32'h0);
        check("rst_comp", 32'(game_complete), 32'h0);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors; expected data rebuilt from the reference LFSR
        exp_data = '0;
        prev_len = 4'd0;
        foreach (vecs[i]) begin
            step(vecs[i].ng, vecs[i].won, vecs[i].lost);
            if (vecs[i].len == 4'd0) begin
                exp_data = '0;
            end else if (vecs[i].len == prev_len + 4'd1) begin
                nib = exp_note(lfsr_prev, exp_data, prev_len);
                exp_data[W-1-4*int'(prev_len) -: 4] = nib;
            end
            prev_len = vecs[i].len;
            check($sformatf("v%0d_valid", i), 32'(level_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_len", i), 32'(level_length), 32'(vecs[i].len));
            check($sformatf("v%0d_comp", i), 32'(game_complete), 32'(vecs[i].comp));
            check($sformatf("v%0d_data", i), 32'(level_data), 32'(exp_data));
        end

        // Asynchronous reset in the middle of a game
        step(1'b1, 1'b0, 1'b0);
        wait_valid();
        step(1'b0, 1'b1, 1'b0);
        wait_valid();
        check("pre_rst_len", 32'(level_length), 32'd2);
        #2 resetn = 1'b0;
        #1;
        check("arst_data", 32'(level_data), 32'h0);
        check("arst_len", 32'(level_length), 32'h0);
        check("arst_valid", 32'(level_valid), 32'h0);
        check("arst_comp", 32'(game_complete), 32'h0);
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random-timing games to full length: note shape and adjacency
        repeats = 0;
        for (int g = 0; g < 200; g++) begin
            step(1'b1, 1'b0, 1'b0);
            wait_valid();
            for (int r = 0; r < 3; r++) begin
                repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0);
                wait_valid();
            end
            check($sformatf("g%0d_len", g), 32'(level_length), 32'd4);
            eq_pairs = 0;
            all_onehot = 1'b1;
            for (int s = 0; s < 4; s++) begin
                if (!$onehot(level_data[W-1-4*s -: 4])) all_onehot = 1'b0;
                if (s > 0 && level_data[W-1-4*s -: 4] == level_data[W-1-4*(s-1) -: 4])
                    eq_pairs++;
            end
            check($sformatf("g%0d_onehot", g), 32'(all_onehot), 32'd1);
            repeats += eq_pairs;
`ifdef NO_REPEAT_EN
            check($sformatf("g%0d_adjacent_equal", g), 32'(eq_pairs), 32'd0);
`endif
        end
`ifndef NO_REPEAT_EN
        check("repeat_seen", 32'(repeats > 0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
